// File: rtl/ter_trit_deser.sv
// Ternary trit deserializer: gathers N_TRITS BCT trits (MSB first) into a word
// and presents both the BCT form and its unsigned binary value on valid/ready.
module ter_trit_deser #(
    parameter int N_TRITS = 4,
    parameter int BIN_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             trit_in,
    input  logic                   trit_valid,
    output logic                   trit_ready,
    output logic [2*N_TRITS-1:0]   word_trits,
    output logic [BIN_W-1:0]       word_bin,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   code_err,
    output logic [3:0]             trit_cnt
);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t                 state, state_n;
    logic [2*N_TRITS-1:0]   shreg, shreg_n, shift_val, word_trits_n;
    logic [BIN_W-1:0]       acc, acc_n, acc_val, word_bin_n;
    logic [3:0]             cnt_n;
    logic                   word_valid_n, code_err_n;
    logic                   accept, illegal;

    // In FULL a trit may only enter when the pending word leaves the same cycle.
    assign trit_ready = (state == COLLECT) ? 1'b1 : word_ready;
    assign accept     = trit_valid && trit_ready;
    assign illegal    = (trit_in == 2'b11);
    assign shift_val  = {shreg[2*N_TRITS-3:0], trit_in};
    assign acc_val    = acc * BIN_W'(3) + BIN_W'(trit_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            shreg      <= '0;
            acc        <= '0;
            trit_cnt   <= '0;
            word_trits <= '0;
            word_bin   <= '0;
            word_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            acc        <= acc_n;
            trit_cnt   <= cnt_n;
            word_trits <= word_trits_n;
            word_bin   <= word_bin_n;
            word_valid <= word_valid_n;
            code_err   <= code_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        acc_n        = acc;
        cnt_n        = trit_cnt;
        word_trits_n = word_trits;
        word_bin_n   = word_bin;
        word_valid_n = word_valid;
        code_err_n   = 1'b0;

        if (state == FULL && word_ready) begin
            state_n      = COLLECT;
            word_valid_n = 1'b0;
        end

        // N_TRITS >= 2, so a trit taken while leaving FULL can never finish a word.
        if (accept) begin
            if (illegal) begin
                code_err_n = 1'b1;
                shreg_n    = '0;
                acc_n      = '0;
                cnt_n      = '0;
            end else if (trit_cnt == 4'(N_TRITS - 1)) begin
                shreg_n      = shift_val;
                word_trits_n = shift_val;
                word_bin_n   = acc_val;
                word_valid_n = 1'b1;
                state_n      = FULL;
                acc_n        = '0;
                cnt_n        = '0;
            end else begin
                shreg_n = shift_val;
                acc_n   = acc_val;
                cnt_n   = trit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ter_trit_deser.sv
// Randomized and directed bench for ter_trit_deser against a word-level ternary model.
module tb_ter_trit_deser;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   trit_in = 2'b00;
    logic         trit_valid = 1'b0;
    logic         trit_ready;
    logic [2*N-1:0] word_trits;
    logic [6:0]   word_bin;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic         code_err;
    logic [3:0]   trit_cnt;

    ter_trit_deser #(.N_TRITS(N), .BIN_W(7)) dut (
        .clk(clk), .rst(rst), .trit_in(trit_in), .trit_valid(trit_valid),
        .trit_ready(trit_ready), .word_trits(word_trits), .word_bin(word_bin),
        .word_valid(word_valid), .word_ready(word_ready), .code_err(code_err),
        .trit_cnt(trit_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: the partial word is a list of trit values; a finished word is valued as sum t_i*3^(N-1-i).
    int          mq[$];
    bit          m_full;
    int          m_bin;
    logic [2*N-1:0] m_trits;
    bit          m_err;
    bit          exp_rdy, seen_rdy;

    task automatic model_clear();
        mq.delete();
        m_full = 0; m_bin = 0; m_trits = '0; m_err = 0;
    endtask

    task automatic do_reset();
        trit_valid = 1'b0;
        word_ready = 1'b0;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Drives one cycle, advances the model, returns #1 after the edge.
    task automatic drive(input logic [1:0] t, input bit v, input bit r);
        int val;
        logic [2*N-1:0] w;
        trit_in = t; trit_valid = v; word_ready = r;
        #1;
        seen_rdy = trit_ready;
        exp_rdy  = !m_full || r;
        m_err = 0;
        if (m_full && r) m_full = 0;
        if (v && exp_rdy) begin
            if (t == 2'b11) begin
                mq.delete();
                m_err = 1;
            end else begin
                mq.push_back(int'(t));
                if (mq.size() == N) begin
                    val = 0; w = '0;
                    foreach (mq[i]) begin
                        val += mq[i] * (3 ** (N - 1 - i));
                        w = (w << 2) | (2*N)'(mq[i]);
                    end
                    m_bin = val; m_trits = w; m_full = 1;
                    mq.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (trit_ready !== 1'b1) begin miscompares++; $display("FAIL reset_trit_ready got %b want 1", trit_ready); end
        vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
        vectors++; if (trit_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_trit_cnt got %0d want 0", trit_cnt); end
        vectors++; if (word_bin !== 7'd0 || word_trits !== 8'd0) begin miscompares++; $display("FAIL reset_word got %0d/%b want 0/0", word_bin, word_trits); end
        vectors++; if (code_err !== 1'b0) begin miscompares++; $display("FAIL reset_code_err got %b want 0", code_err); end
    endtask

    task automatic test_basic_word();
        drive(2'd2, 1, 1); drive(2'd1, 1, 1); drive(2'd0, 1, 1);
        vectors++; if (trit_cnt !== 4'd3 || word_valid !== 1'b0) begin miscompares++; $display("FAIL t1_partial cnt=%0d vld=%b want 3/0", trit_cnt, word_valid); end
        drive(2'd2, 1, 1);
        vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid got %b want 1", word_valid); end
        vectors++; if (word_trits !== 8'b10_01_00_10) begin miscompares++; $display("FAIL t1_trits got %b want 10010010", word_trits); end
        vectors++; if (word_bin !== 7'd65) begin miscompares++; $display("FAIL t1_bin got %0d want 65", word_bin); end
        drive(2'd0, 0, 1);
        vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL t1_taken got %b want 0", word_valid); end
    endtask

    task automatic test_extremes();
        repeat (4) drive(2'd2, 1, 0);
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd80) begin miscompares++; $display("FAIL t2_max vld=%b bin=%0d want 1/80", word_valid, word_bin); end
        drive(2'd0, 1, 1);
        repeat (3) drive(2'd0, 1, 1);
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd0 || word_trits !== 8'd0) begin miscompares++; $display("FAIL t2_min vld=%b bin=%0d want 1/0", word_valid, word_bin); end
        drive(2'd0, 0, 1);
    endtask

    task automatic test_backpressure();
        drive(2'd1, 1, 0); drive(2'd0, 1, 0); drive(2'd0, 1, 0); drive(2'd0, 1, 0);
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd27) begin miscompares++; $display("FAIL t3_word vld=%b bin=%0d want 1/27", word_valid, word_bin); end
        for (int i = 0; i < 10; i++) begin
            drive(2'd1, 1, 0);
            vectors++;
            if (seen_rdy !== 1'b0 || word_valid !== 1'b1 || word_bin !== 7'd27 || word_trits !== 8'b01_00_00_00 || trit_cnt !== 4'd0) begin
                miscompares++;
                $display("FAIL t3_hold cyc %0d rdy=%b vld=%b bin=%0d cnt=%0d want 0/1/27/0", i, seen_rdy, word_valid, word_bin, trit_cnt);
            end
        end
        drive(2'd1, 1, 1);
        vectors++; if (seen_rdy !== 1'b1 || word_valid !== 1'b0 || trit_cnt !== 4'd1) begin miscompares++; $display("FAIL t3_release rdy=%b vld=%b cnt=%0d want 1/0/1", seen_rdy, word_valid, trit_cnt); end
        drive(2'd0, 1, 1); drive(2'd0, 1, 1); drive(2'd0, 1, 1);
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd27) begin miscompares++; $display("FAIL t3_next vld=%b bin=%0d want 1/27", word_valid, word_bin); end
        drive(2'd0, 0, 1);
    endtask

    task automatic test_code_err();
        logic [1:0] seq [7];
        seq = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 7; i++) begin
            drive(seq[i], 1, 1);
            vectors++;
            if (code_err !== (i == 2)) begin miscompares++; $display("FAIL t4_err accept %0d got %b want %b", i + 1, code_err, (i == 2)); end
        end
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd58 || word_trits !== 8'b10_00_01_01) begin miscompares++; $display("FAIL t4_word vld=%b bin=%0d want 1/58", word_valid, word_bin); end
        drive(2'd0, 0, 1);
    endtask

    task automatic test_mid_reset();
        drive(2'd2, 1, 1); drive(2'd2, 1, 1);
        do_reset();
        vectors++; if (trit_cnt !== 4'd0 || word_valid !== 1'b0) begin miscompares++; $display("FAIL t5_reset cnt=%0d vld=%b want 0/0", trit_cnt, word_valid); end
        drive(2'd0, 1, 1); drive(2'd0, 1, 1); drive(2'd1, 1, 1); drive(2'd2, 1, 0);
        vectors++; if (word_valid !== 1'b1 || word_bin !== 7'd5) begin miscompares++; $display("FAIL t5_word vld=%b bin=%0d want 1/5", word_valid, word_bin); end
        do_reset();
        vectors++; if (word_valid !== 1'b0 || word_bin !== 7'd0) begin miscompares++; $display("FAIL t5_pending_lost vld=%b bin=%0d want 0/0", word_valid, word_bin); end
    endtask

    task automatic test_back_to_back();
        int words = 0;
        for (int c = 0; c < 3 * N; c++) begin
            drive(2'($urandom_range(0, 2)), 1, 1);
            vectors++;
            if (word_valid !== ((c % N) == N - 1) || (word_valid && word_bin !== 7'(m_bin))) begin
                miscompares++;
                $display("FAIL b2b cyc %0d vld=%b bin=%0d want %b/%0d", c, word_valid, word_bin, ((c % N) == N - 1), m_bin);
            end
            if (word_valid) words++;
        end
        vectors++; if (words != 3) begin miscompares++; $display("FAIL b2b_words got %0d want 3", words); end
        drive(2'd0, 0, 1);
    endtask

    task automatic test_random();
        logic [1:0] t;
        for (int c = 0; c < 600; c++) begin
            t = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            drive(t, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            vectors++;
            if (seen_rdy !== exp_rdy || word_valid !== m_full || code_err !== m_err ||
                trit_cnt !== 4'(mq.size()) || word_bin !== 7'(m_bin) || word_trits !== m_trits) begin
                miscompares++;
                $display("FAIL rand cyc %0d rdy=%b/%b vld=%b/%b err=%b/%b cnt=%0d/%0d bin=%0d/%0d trits=%b/%b",
                         c, seen_rdy, exp_rdy, word_valid, m_full, code_err, m_err,
                         trit_cnt, mq.size(), word_bin, m_bin, word_trits, m_trits);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_extremes();
        test_backpressure();
        test_code_err();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
